video_pattern_gen: RTL and testbench

VIDEO_PATTERN_GEN -- requirements
Module: video_pattern_gen

---
 rtl/video_pkg.sv | 55 +++++
 rtl/video_timing.sv | 76 +++++++
 rtl/video_pattern_gen.sv | 154 +++++++++++++++
 tb/tb_video_pattern_gen.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - pattern encodings, 640x480 timing defaults and colour-bar palette
package video_pkg;

    typedef enum logic [1:0] {
        PAT_BARS  = 2'd0,
        PAT_RAMP  = 2'd1,
        PAT_CHECK = 2'd2,
        PAT_SOLID = 2'd3
    } pattern_e;

    localparam int CNT_W = 12;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
    localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
    localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] BAR_RED     = 24'hFF0000;
    localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
    localparam logic [23:0] BAR_BLACK   = 24'h000000;

    // Per-pixel context carried from the counter stage to the colour stage.
    typedef struct packed {
        logic       active;
        logic       hsync;
        logic       vsync;
        logic       first;
        logic       chk;
        logic [7:0] grey;
        logic [2:0] bar;
    } pix_ctx_s;

    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_colour = BAR_WHITE;
            3'd1:    bar_colour = BAR_YELLOW;
            3'd2:    bar_colour = BAR_CYAN;
            3'd3:    bar_colour = BAR_GREEN;
            3'd4:    bar_colour = BAR_MAGENTA;
            3'd5:    bar_colour = BAR_RED;
            3'd6:    bar_colour = BAR_BLUE;
            default: bar_colour = BAR_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/video_timing.sv
// rtl/video_timing.sv - raster counters with sync and active-video decode
module video_timing
    import video_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    output logic [7:0] h_low,
    output logic       v_bit5,
    output logic       h_last,
    output logic       frame_first,
    output logic       active,
    output logic       hsync,
    output logic       vsync
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_MAX  = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_MAX  = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
    logic             v_last;

    assign h_last = (h_cnt_q == H_MAX);
    assign v_last = (v_cnt_q == V_MAX);

    // Disabled counters park at the origin so a restart always begins a fresh frame.
    always_comb begin
        h_cnt_d = h_cnt_q + CNT_W'(1);
        v_cnt_d = v_cnt_q;
        if (!enable) begin
            h_cnt_d = '0;
            v_cnt_d = '0;
        end else if (h_last) begin
            h_cnt_d = '0;
            v_cnt_d = v_last ? '0 : v_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign h_low       = h_cnt_q[7:0];
    assign v_bit5      = v_cnt_q[5];
    assign frame_first = enable && (h_cnt_q == '0) && (v_cnt_q == '0);
    assign active      = enable && (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    assign hsync       = (enable && (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END)) ? SYNC_POL : ~SYNC_POL;
    assign vsync       = (enable && (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END)) ? SYNC_POL : ~SYNC_POL;

endmodule

// File: rtl/video_pattern_gen.sv
// rtl/video_pattern_gen.sv - test-pattern source with two-stage registered video outputs
module video_pattern_gen
    import video_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    input  logic [23:0] solid_rgb,
    output logic [23:0] vdata,
    output logic        hsync,
    output logic        vsync,
    output logic        blank,
    output logic        frame_start
);

    localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(H_ACTIVE / 8 - 1);

    localparam pix_ctx_s CTX_IDLE = '{
        active: 1'b0, hsync: ~SYNC_POL, vsync: ~SYNC_POL,
        first: 1'b0, chk: 1'b0, grey: 8'd0, bar: 3'd0
    };

    logic [7:0] t_h_low;
    logic       t_v_bit5;
    logic       t_h_last;
    logic       t_first;
    logic       t_active;
    logic       t_hsync;
    logic       t_vsync;

    video_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .SYNC_POL (SYNC_POL)
    ) u_timing (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .h_low       (t_h_low),
        .v_bit5      (t_v_bit5),
        .h_last      (t_h_last),
        .frame_first (t_first),
        .active      (t_active),
        .hsync       (t_hsync),
        .vsync       (t_vsync)
    );

    pattern_e         pat_q, pat_d;
    logic [23:0]      solid_q, solid_d;
    logic [CNT_W-1:0] bar_px_q, bar_px_d;
    logic [2:0]       bar_idx_q, bar_idx_d;
    pix_ctx_s         s1_q, s1_d;
    logic [23:0]      pix;
    logic [23:0]      vdata_q, vdata_d;
    logic             blank_q, blank_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             frame_start_q, frame_start_d;

    always_comb begin
        pat_d   = pat_q;
        solid_d = solid_q;
        if (t_first) begin
            pat_d   = pattern_e'(pattern_sel);
            solid_d = solid_rgb;
        end

        // Bar index tracks h_cnt by counting bar widths, saturating at the last bar.
        bar_px_d  = bar_px_q + CNT_W'(1);
        bar_idx_d = bar_idx_q;
        if (!enable || t_h_last) begin
            bar_px_d  = '0;
            bar_idx_d = '0;
        end else if (bar_px_q == BAR_LAST) begin
            bar_px_d = '0;
            if (bar_idx_q != 3'd7) begin
                bar_idx_d = bar_idx_q + 3'd1;
            end
        end

        s1_d.active = t_active;
        s1_d.hsync  = t_hsync;
        s1_d.vsync  = t_vsync;
        s1_d.first  = t_first;
        s1_d.chk    = t_h_low[5] ^ t_v_bit5;
        s1_d.grey   = t_h_low;
        s1_d.bar    = bar_idx_q;

        pix = 24'h000000;
        case (pat_q)
            PAT_BARS:  pix = bar_colour(s1_q.bar);
            PAT_RAMP:  pix = {3{s1_q.grey}};
            PAT_CHECK: pix = s1_q.chk ? BAR_WHITE : BAR_BLACK;
            PAT_SOLID: pix = solid_q;
            default:   pix = 24'h000000;
        endcase

        vdata_d       = s1_q.active ? pix : 24'h000000;
        blank_d       = s1_q.active;
        hsync_d       = s1_q.hsync;
        vsync_d       = s1_q.vsync;
        frame_start_d = s1_q.first;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pat_q         <= PAT_BARS;
            solid_q       <= 24'h000000;
            bar_px_q      <= '0;
            bar_idx_q     <= '0;
            s1_q          <= CTX_IDLE;
            vdata_q       <= 24'h000000;
            blank_q       <= 1'b0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            frame_start_q <= 1'b0;
        end else begin
            pat_q         <= pat_d;
            solid_q       <= solid_d;
            bar_px_q      <= bar_px_d;
            bar_idx_q     <= bar_idx_d;
            s1_q          <= s1_d;
            vdata_q       <= vdata_d;
            blank_q       <= blank_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vdata       = vdata_q;
    assign blank       = blank_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_video_pattern_gen.sv
// tb/tb_video_pattern_gen.sv - randomized bench for video_pattern_gen against a raster-position model
module tb_video_pattern_gen;

    localparam int   HA  = 72;
    localparam int   HFP = 4;
    localparam int   HS  = 8;
    localparam int   HBP = 4;
    localparam int   VA  = 36;
    localparam int   VFP = 2;
    localparam int   VS  = 3;
    localparam int   VBP = 3;
    localparam logic POL = 1'b1;
    localparam int   H_TOTAL = HA + HFP + HS + HBP;
    localparam int   V_TOTAL = VA + VFP + VS + VBP;
    localparam int   FRAME   = H_TOTAL * V_TOTAL;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [1:0]  pattern_sel;
    logic [23:0] solid_rgb;
    logic [23:0] vdata;
    logic        hsync;
    logic        vsync;
    logic        blank;
    logic        frame_start;

    video_pattern_gen #(
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
        .SYNC_POL (POL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .pattern_sel (pattern_sel),
        .solid_rgb   (solid_rgb),
        .vdata       (vdata),
        .hsync       (hsync),
        .vsync       (vsync),
        .blank       (blank),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        live;
        int          x;
        int          y;
        logic [23:0] vdata;
        logic        blank;
        logic        hs;
        logic        vs;
        logic        fs;
    } exp_t;

    int          n_checks = 0;
    int          n_errors = 0;
    int          pos = 0;
    int          frame_pat = 0;
    logic [23:0] frame_solid = 24'h0;
    exp_t        s1;
    exp_t        last_exp;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] ref_bar(input int i);
        case (i)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    function automatic exp_t idle_exp();
        exp_t e;
        e.live = 1'b0; e.x = -1; e.y = -1;
        e.vdata = 24'h0; e.blank = 1'b0; e.hs = ~POL; e.vs = ~POL; e.fs = 1'b0;
        return e;
    endfunction

    // Expected output for linear raster position p of a frame started from the origin.
    function automatic exp_t model_at(input int p);
        exp_t e;
        int x, y;
        x = p % H_TOTAL;
        y = p / H_TOTAL;
        e.live  = 1'b1; e.x = x; e.y = y;
        e.blank = (x < HA) && (y < VA);
        e.hs    = (x >= HA + HFP && x < HA + HFP + HS) ? POL : ~POL;
        e.vs    = (y >= VA + VFP && y < VA + VFP + VS) ? POL : ~POL;
        e.fs    = (p == 0);
        e.vdata = 24'h0;
        if (e.blank) begin
            case (frame_pat)
                0:       e.vdata = ref_bar(x / (HA / 8));
                1:       e.vdata = {3{8'(x % 256)}};
                2:       e.vdata = (((x / 32) + (y / 32)) % 2 == 1) ? 24'hFFFFFF : 24'h0;
                default: e.vdata = frame_solid;
            endcase
        end
        return e;
    endfunction

    function automatic logic [31:0] pack(input exp_t e);
        return {4'h0, e.vdata, e.blank, e.hs, e.vs, e.fs};
    endfunction

    function automatic logic [31:0] dut_pack();
        return {4'h0, vdata, blank, hsync, vsync, frame_start};
    endfunction

    task automatic step();
        exp_t cur, out;
        if (reset) begin
            out = idle_exp(); s1 = idle_exp();
            pos = 0; frame_pat = 0; frame_solid = 24'h0;
        end else begin
            if (enable) begin
                if (pos == 0) begin
                    frame_pat   = int'(pattern_sel);
                    frame_solid = solid_rgb;
                end
                cur = model_at(pos);
                pos = (pos + 1) % FRAME;
            end else begin
                cur = idle_exp();
                pos = 0;
            end
            out = s1;
            s1  = cur;
        end
        @(posedge clk);
        #1;
        last_exp = out;
        check("cycle", dut_pack(), pack(out));
    endtask

    task automatic run_to(input int x, input int y, input string tag);
        for (int i = 0; i < 2 * FRAME + 8; i++) begin
            step();
            if (last_exp.live && last_exp.x == x && last_exp.y == y) return;
        end
        check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic check_px(input int x, input int y, input logic [23:0] exp, input string tag);
        run_to(x, y, tag);
        check(tag, {8'h0, vdata}, {8'h0, exp});
    endtask

    task automatic measure_frame(input string tag);
        int n_hs, n_vs, n_bl, n_fs;
        n_hs = 0; n_vs = 0; n_bl = 0; n_fs = 0;
        run_to(0, 0, tag);
        for (int i = 0; i < FRAME; i++) begin
            if (i != 0) step();
            if (hsync == POL) n_hs++;
            if (vsync == POL) n_vs++;
            if (blank) n_bl++;
            if (frame_start) n_fs++;
        end
        check({tag, "_hsync_cycles"}, n_hs, V_TOTAL * HS);
        check({tag, "_vsync_cycles"}, n_vs, VS * H_TOTAL);
        check({tag, "_active_cycles"}, n_bl, HA * VA);
        check({tag, "_fs_count"}, n_fs, 1);
        step();
        check({tag, "_next_fs"}, {31'b0, frame_start}, 32'd1);
    endtask

    initial begin
        int rx, ry;
        s1 = idle_exp();
        last_exp = idle_exp();
        reset = 1'b1; enable = 1'b0; pattern_sel = 2'd0; solid_rgb = 24'h0;
        repeat (3) step();
        check("reset_idle", dut_pack(), pack(idle_exp()));

        reset = 1'b0;
        repeat (4) step();
        check("disabled_idle", dut_pack(), pack(idle_exp()));

        enable = 1'b1;
        step();
        check("enable_fs_early", {31'b0, frame_start}, 32'd0);
        step();
        check("enable_fs", {31'b0, frame_start}, 32'd1);

        check_px(0, 5, 24'hFFFFFF, "bar0_first");
        check_px(HA / 8, 5, 24'hFFFF00, "bar1_first");
        check_px(6 * HA / 8, 5, 24'h0000FF, "bar6_first");
        check_px(HA - 1, 5, 24'h000000, "bar7_last");
        check_px(HA, 5, 24'h000000, "blank_px");
        check("blank_low", {31'b0, blank}, 32'd0);
        measure_frame("bars");

        run_to(0, 10, "sel_change");
        pattern_sel = 2'd2;
        check_px(20, 20, 24'h00FFFF, "midframe_hold");
        check_px(0, 0, 24'h000000, "chk_0_0");
        check_px(32, 0, 24'hFFFFFF, "chk_32_0");
        check_px(32, 33, 24'h000000, "chk_32_33");

        pattern_sel = 2'd1;
        check_px(70, 3, 24'h464646, "ramp_70");

        pattern_sel = 2'd3;
        solid_rgb   = 24'h123456;
        run_to(0, 0, "solid_start");
        rx = $urandom_range(HA - 1);
        ry = $urandom_range(VA - 1, 1);
        check_px(rx, ry, 24'h123456, "solid_px");
        measure_frame("solid");

        run_to(5, 20, "rst_mid");
        reset = 1'b1;
        step();
        check("rst_idle", dut_pack(), pack(idle_exp()));
        reset = 1'b0;
        step();
        check("rst_fs_early", {31'b0, frame_start}, 32'd0);
        step();
        check("rst_fs_lat2", {31'b0, frame_start}, 32'd1);

        run_to(5, 30, "en_mid");
        enable = 1'b0;
        step();
        step();
        check("en_off_idle", dut_pack(), pack(idle_exp()));
        repeat (8) step();
        enable = 1'b1;
        step();
        check("en_fs_early", {31'b0, frame_start}, 32'd0);
        step();
        check("en_fs_lat2", {31'b0, frame_start}, 32'd1);
        measure_frame("restart");

        for (int i = 0; i < 15000; i++) begin
            reset = 1'b0;
            if ($urandom_range(199) == 0) begin
                pattern_sel = 2'($urandom_range(3));
                solid_rgb   = 24'($urandom);
            end
            if (enable) begin
                if ($urandom_range(2499) == 0) enable = 1'b0;
            end else if ($urandom_range(7) == 0) begin
                enable = 1'b1;
            end
            if ($urandom_range(3999) == 0) reset = 1'b1;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
